// File: rtl/wb_regfile_if.sv
// MEM/WB write-back and ID read-port signal bundle for wb_regfile.
// master drives the pipeline side and the read addresses; slave is the register file.
interface wb_regfile_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
);
    logic              reg_write;
    logic              mem_to_reg;
    logic [DATA_W-1:0] mem_read_data;
    logic [DATA_W-1:0] alu_data;
    logic [ADDR_W-1:0] wb_reg;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;
    logic [DATA_W-1:0] wb_data;
    logic              wb_valid;
    logic [CNT_W-1:0]  wb_count;

    modport master (
        output reg_write, mem_to_reg, mem_read_data, alu_data, wb_reg, rd_addr_a, rd_addr_b,
        input  rd_data_a, rd_data_b, wb_data, wb_valid, wb_count
    );

    modport slave (
        input  reg_write, mem_to_reg, mem_read_data, alu_data, wb_reg, rd_addr_a, rd_addr_b,
        output rd_data_a, rd_data_b, wb_data, wb_valid, wb_count
    );
endinterface

// File: rtl/wb_regfile.sv
// Write-back select, integer register file (r0 reads zero), two combinational read ports
// and a retired-write counter. Define WB_BYPASS_EN to forward the write-back value to reads.
module wb_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    wb_regfile_if.slave  bus
);
    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] wb_data;
    logic              wb_valid;
    logic [CNT_W-1:0]  wb_count;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;

    assign wb_data  = bus.mem_to_reg ? bus.mem_read_data : bus.alu_data;
    // Gating with rst_n keeps the valid flag and the bypass quiet while reset is held.
    assign wb_valid = rst_n & bus.reg_write & (bus.wb_reg != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            wb_count <= '0;
        end else if (wb_valid) begin
            regs[bus.wb_reg] <= wb_data;
            wb_count         <= wb_count + CNT_W'(1);
        end
    end

    always_comb begin
        rd_data_a = '0;
        if (rst_n && bus.rd_addr_a != '0) begin
            rd_data_a = regs[bus.rd_addr_a];
`ifdef WB_BYPASS_EN
            if (wb_valid && bus.rd_addr_a == bus.wb_reg) begin
                rd_data_a = wb_data;
            end
`endif
        end
    end

    always_comb begin
        rd_data_b = '0;
        if (rst_n && bus.rd_addr_b != '0) begin
            rd_data_b = regs[bus.rd_addr_b];
`ifdef WB_BYPASS_EN
            if (wb_valid && bus.rd_addr_b == bus.wb_reg) begin
                rd_data_b = wb_data;
            end
`endif
        end
    end

    assign bus.rd_data_a = rd_data_a;
    assign bus.rd_data_b = rd_data_b;
    assign bus.wb_data   = wb_data;
    assign bus.wb_valid  = wb_valid;
    assign bus.wb_count  = wb_count;
endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile; the counter is built 4 bits wide so that
// wrap-around is reachable in a handful of writes.
module tb_wb_regfile;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    wb_regfile_if #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) bus ();

    wb_regfile #(.DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic drive(input logic we, input logic m2r, input logic [DW-1:0] mdata,
                         input logic [DW-1:0] adata, input logic [AW-1:0] wreg);
        bus.reg_write     = we;
        bus.mem_to_reg    = m2r;
        bus.mem_read_data = mdata;
        bus.alu_data      = adata;
        bus.wb_reg        = wreg;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        drive(1'b1, 1'b0, 32'h0, 32'h1234, 5'd3);
        bus.rd_addr_a = 5'd3;
        bus.rd_addr_b = 5'd0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (bus.rd_data_a !== 32'h0) begin
            n_fail++; $display("FAIL reset_rda: got %h expected %h", bus.rd_data_a, 32'h0);
        end
        n_checks++;
        if (bus.wb_count !== 4'd0) begin
            n_fail++; $display("FAIL reset_count: got %0d expected 0", bus.wb_count);
        end
        n_checks++;
        if (bus.wb_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.wb_valid);
        end
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        rst_n = 1'b1;
    endtask

    task automatic test_alu_path;
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h0, 32'hDEADBEEF, 5'd5);
        bus.rd_addr_a = 5'd5;
        #1;
        n_checks++;
        if (bus.wb_valid !== 1'b1) begin
            n_fail++; $display("FAIL alu_valid: got %b expected 1", bus.wb_valid);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.rd_data_a !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL alu_rda: got %h expected deadbeef", bus.rd_data_a);
        end
        n_checks++;
        if (bus.wb_count !== 4'd1) begin
            n_fail++; $display("FAIL alu_count: got %0d expected 1", bus.wb_count);
        end
        bus.reg_write = 1'b0;
    endtask

    task automatic test_load_path;
        @(negedge clk);
        drive(1'b1, 1'b1, 32'hCAFEF00D, 32'h1, 5'd31);
        bus.rd_addr_b = 5'd31;
        #1;
        n_checks++;
        if (bus.wb_data !== 32'hCAFEF00D) begin
            n_fail++; $display("FAIL load_wbdata: got %h expected cafef00d", bus.wb_data);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.rd_data_b !== 32'hCAFEF00D) begin
            n_fail++; $display("FAIL load_rdb: got %h expected cafef00d", bus.rd_data_b);
        end
        n_checks++;
        if (bus.rd_data_a !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL load_r5_kept: got %h expected deadbeef", bus.rd_data_a);
        end
        n_checks++;
        if (bus.wb_count !== 4'd2) begin
            n_fail++; $display("FAIL load_count: got %0d expected 2", bus.wb_count);
        end
        bus.reg_write = 1'b0;
    endtask

    task automatic test_r0;
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h0, 32'hFFFFFFFF, 5'd0);
        bus.rd_addr_a = 5'd0;
        #1;
        n_checks++;
        if (bus.wb_valid !== 1'b0) begin
            n_fail++; $display("FAIL r0_valid: got %b expected 0", bus.wb_valid);
        end
        n_checks++;
        if (bus.wb_data !== 32'hFFFFFFFF) begin
            n_fail++; $display("FAIL r0_wbdata: got %h expected ffffffff", bus.wb_data);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.rd_data_a !== 32'h0) begin
            n_fail++; $display("FAIL r0_rda: got %h expected 0", bus.rd_data_a);
        end
        n_checks++;
        if (bus.wb_count !== 4'd2) begin
            n_fail++; $display("FAIL r0_count: got %0d expected 2", bus.wb_count);
        end
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h0, 32'h99, 5'd9);
        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0, 32'h1111, 5'd9);
        bus.rd_addr_a = 5'd9;
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.rd_data_a !== 32'h99) begin
            n_fail++; $display("FAIL nowrite_r9: got %h expected 99", bus.rd_data_a);
        end
        n_checks++;
        if (bus.wb_count !== 4'd3) begin
            n_fail++; $display("FAIL nowrite_count: got %0d expected 3", bus.wb_count);
        end
    endtask

    task automatic test_bypass;
        logic [DW-1:0] exp_pre;
`ifdef WB_BYPASS_EN
        exp_pre = 32'h55;
`else
        exp_pre = 32'h11;
`endif
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h0, 32'h11, 5'd7);
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h0, 32'h55, 5'd7);
        bus.rd_addr_a = 5'd7;
        bus.rd_addr_b = 5'd7;
        #1;
        n_checks++;
        if (bus.rd_data_a !== exp_pre) begin
            n_fail++; $display("FAIL bypass_pre_a: got %h expected %h", bus.rd_data_a, exp_pre);
        end
        n_checks++;
        if (bus.rd_data_b !== exp_pre) begin
            n_fail++; $display("FAIL bypass_pre_b: got %h expected %h", bus.rd_data_b, exp_pre);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.rd_data_a !== 32'h55 || bus.rd_data_b !== 32'h55) begin
            n_fail++; $display("FAIL bypass_post: got a=%h b=%h expected 55", bus.rd_data_a, bus.rd_data_b);
        end
        n_checks++;
        if (bus.wb_count !== 4'd5) begin
            n_fail++; $display("FAIL bypass_count: got %0d expected 5", bus.wb_count);
        end
        bus.reg_write = 1'b0;
    endtask

    task automatic test_wrap_reset;
        @(negedge clk);
        bus.reg_write = 1'b0;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            drive(1'b1, 1'b0, 32'h0, 32'h100 + i, 5'((i % 15) + 1));
            @(posedge clk);
            #1;
            if (i == 14) begin
                n_checks++;
                if (bus.wb_count !== 4'd15) begin
                    n_fail++; $display("FAIL wrap_15: got %0d expected 15", bus.wb_count);
                end
            end
        end
        bus.reg_write = 1'b0;
        n_checks++;
        if (bus.wb_count !== 4'd0) begin
            n_fail++; $display("FAIL wrap_0: got %0d expected 0", bus.wb_count);
        end
        bus.rd_addr_a = 5'd1;
        bus.rd_addr_b = 5'd15;
        #1;
        n_checks++;
        if (bus.rd_data_a !== 32'h10F || bus.rd_data_b !== 32'h10E) begin
            n_fail++; $display("FAIL wrap_data: got r1=%h r15=%h expected 10f 10e", bus.rd_data_a, bus.rd_data_b);
        end
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h0, 32'h3, 5'd3);
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.wb_count !== 4'd1) begin
            n_fail++; $display("FAIL pre_reset_count: got %0d expected 1", bus.wb_count);
        end
        @(negedge clk);
        drive(1'b1, 1'b0, 32'h0, 32'h77, 5'd2);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.rd_data_a !== 32'h0 || bus.rd_data_b !== 32'h0) begin
            n_fail++; $display("FAIL midreset_reads: got a=%h b=%h expected 0", bus.rd_data_a, bus.rd_data_b);
        end
        n_checks++;
        if (bus.wb_count !== 4'd0 || bus.wb_valid !== 1'b0) begin
            n_fail++; $display("FAIL midreset_state: got count=%0d valid=%b expected 0 0", bus.wb_count, bus.wb_valid);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        bus.rd_addr_a = 5'd2;
        bus.rd_addr_b = 5'd3;
        @(posedge clk);
        #1;
        bus.reg_write = 1'b0;
        n_checks++;
        if (bus.rd_data_a !== 32'h77 || bus.rd_data_b !== 32'h0) begin
            n_fail++; $display("FAIL release_write: got r2=%h r3=%h expected 77 0", bus.rd_data_a, bus.rd_data_b);
        end
        n_checks++;
        if (bus.wb_count !== 4'd1) begin
            n_fail++; $display("FAIL release_count: got %0d expected 1", bus.wb_count);
        end
    endtask

    initial begin
        drive(1'b0, 1'b0, 32'h0, 32'h0, 5'd0);
        bus.rd_addr_a = 5'd0;
        bus.rd_addr_b = 5'd0;
        test_reset();
        test_alu_path();
        test_load_path();
        test_r0();
        test_bypass();
        test_wrap_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
